fp_divider_param: RTL

- Iterative, parametrised IEEE-754-style floating-point divider. Generalises the fixed single-precision divider to arbitrary exponent and fraction widths, with a selectable rounding mode.
- Takes packed operands directly and does its own unpack and classification. Runs a radix-2 restoring mantissa division, then normalises, rounds and packs the result.
- Sits beside the adder and multiplier in the FPU datapath and uses the same data_valid handshake.
- Adds underflow (flush-to-zero) and a divide-by-zero flag that is separate from invalid-operation.

---
 rtl/fp_divider_param_if.sv | 33 +++
 rtl/fp_divider_param.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fp_divider_param_if.sv
// Operand/result bundle for the parametrised divider: operand strobe, packed
// operands, busy, result strobe, quotient and exception flags.
interface fp_divider_param_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         data_valid_i;
  logic [W-1:0] x_i;
  logic [W-1:0] y_i;
  logic         busy_o;
  logic         data_valid_o;
  logic [W-1:0] z_o;
  logic         except_invalid_operation_o;
  logic         except_div_by_zero_o;
  logic         except_overflow_o;
  logic         except_underflow_o;

  modport master (
    output data_valid_i, x_i, y_i,
    input  busy_o, data_valid_o, z_o,
    input  except_invalid_operation_o, except_div_by_zero_o,
    input  except_overflow_o, except_underflow_o
  );

  modport slave (
    input  data_valid_i, x_i, y_i,
    output busy_o, data_valid_o, z_o,
    output except_invalid_operation_o, except_div_by_zero_o,
    output except_overflow_o, except_underflow_o
  );
endinterface

// File: rtl/fp_divider_param.sv
// Iterative parametrised floating-point divider: unpack/classify, radix-2
// restoring mantissa division, normalise, round (truncate or RNE) and pack.
module fp_divider_param #(
  parameter int EXP_W      = 8,
  parameter int FRAC_W     = 23,
  parameter int ROUND_MODE = 1
) (
  input logic                clk_i,
  input logic                rst_i,
  fp_divider_param_if.slave  bus
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int M  = FRAC_W + 1;
  localparam int Q  = FRAC_W + 3;
  localparam int CW = $clog2(Q);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  // state    | meaning
  // IDLE     | waiting for data_valid_i
  // CLASSIFY | special-case resolution or division setup
  // DIVIDE   | one quotient bit per cycle, Q cycles
  // NORM     | single left shift when quotient < 1
  // ROUND    | round, range check, pack, emit result
  typedef enum logic [2:0] {S_IDLE, S_CLASSIFY, S_DIVIDE, S_NORM, S_ROUND} state_t;
  state_t state_q, state_d;

  logic [W-1:0]           x_q, y_q;
  logic [M:0]             rem_q;
  logic [M-1:0]           div_q;
  logic [Q-1:0]           quo_q;
  logic signed [EW-1:0]   e_q;
  logic [CW-1:0]          cnt_q;
  logic                   busy_q, dv_q;
  logic [W-1:0]           z_q;
  logic [3:0]             flags_q;

  logic                   sign;
  logic [EXP_W-1:0]       ex, ey;
  logic [FRAC_W-1:0]      fx, fy;
  logic                   x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;

  assign sign   = x_q[W-1] ^ y_q[W-1];
  assign ex     = x_q[W-2:FRAC_W];
  assign ey     = y_q[W-2:FRAC_W];
  assign fx     = x_q[FRAC_W-1:0];
  assign fy     = y_q[FRAC_W-1:0];
  assign x_nan  = (ex == '1) && (fx != '0);
  assign y_nan  = (ey == '1) && (fy != '0);
  assign x_inf  = (ex == '1) && (fx == '0);
  assign y_inf  = (ey == '1) && (fy == '0);
  assign x_zero = (ex == '0);
  assign y_zero = (ey == '0);

  // flags are packed {invalid, div_by_zero, overflow, underflow}
  logic           spec_hit;
  logic [W-1:0]   spec_z;
  logic [3:0]     spec_flags;

  always_comb begin
    spec_hit   = 1'b1;
    spec_z     = '0;
    spec_flags = 4'b0000;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      spec_z     = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b1}}};
      spec_flags = 4'b1000;
    end else if (y_zero && !x_inf) begin
      spec_z     = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      spec_flags = 4'b0100;
    end else if (x_inf) begin
      spec_z     = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (y_inf || x_zero) begin
      spec_z     = {sign, {(W-1){1'b0}}};
    end else begin
      spec_hit   = 1'b0;
    end
  end

  logic           rem_ge;
  logic [M:0]     rem_sub, rem_nxt;

  assign rem_ge  = rem_q >= {1'b0, div_q};
  assign rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
  assign rem_nxt = rem_sub << 1;

  logic                 round_up;
  logic [M:0]           mant_r;
  logic signed [EW-1:0] e_r;
  logic [W-1:0]         rnd_z;
  logic [3:0]           rnd_flags;

  always_comb begin
    round_up  = (ROUND_MODE == 1) && quo_q[1] && (quo_q[0] || (|rem_q) || quo_q[2]);
    mant_r    = {1'b0, quo_q[Q-1:2]} + (M+1)'(round_up);
    e_r       = e_q + EW'(mant_r[M]);
    rnd_flags = 4'b0000;
    if (e_r >= EMAX) begin
      rnd_z     = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      rnd_flags = 4'b0010;
    end else if (e_r <= 0) begin
      rnd_z     = {sign, {(W-1){1'b0}}};
      rnd_flags = 4'b0001;
    end else begin
      // a carry-out leaves mant_r = 10..0, so its low bits are the zero fraction
      rnd_z     = {sign, e_r[EXP_W-1:0], mant_r[FRAC_W-1:0]};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (bus.data_valid_i) state_d = S_CLASSIFY;
      S_CLASSIFY: state_d = spec_hit ? S_IDLE : S_DIVIDE;
      S_DIVIDE:   if (cnt_q == '0) state_d = S_NORM;
      S_NORM:     state_d = S_ROUND;
      S_ROUND:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0; y_q <= '0; rem_q <= '0; div_q <= '0; quo_q <= '0;
      e_q <= '0; cnt_q <= '0;
      busy_q <= 1'b0; dv_q <= 1'b0; z_q <= '0; flags_q <= '0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.data_valid_i) begin
          x_q    <= bus.x_i;
          y_q    <= bus.y_i;
          busy_q <= 1'b1;
        end
        S_CLASSIFY: if (spec_hit) begin
          z_q     <= spec_z;
          flags_q <= spec_flags;
          dv_q    <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          rem_q <= {2'b01, fx};
          div_q <= {1'b1, fy};
          e_q   <= $signed(EW'(ex)) - $signed(EW'(ey)) + BIAS;
          quo_q <= '0;
          cnt_q <= CW'(Q - 1);
        end
        S_DIVIDE: begin
          quo_q <= {quo_q[Q-2:0], rem_ge};
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - 1'b1;
        end
        S_NORM: if (!quo_q[Q-1]) begin
          quo_q <= {quo_q[Q-2:0], 1'b0};
          e_q   <= e_q - 1'b1;
        end
        S_ROUND: begin
          z_q     <= rnd_z;
          flags_q <= rnd_flags;
          dv_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o                     = busy_q;
  assign bus.data_valid_o               = dv_q;
  assign bus.z_o                        = z_q;
  assign bus.except_invalid_operation_o = flags_q[3];
  assign bus.except_div_by_zero_o       = flags_q[2];
  assign bus.except_overflow_o          = flags_q[1];
  assign bus.except_underflow_o         = flags_q[0];
endmodule
